// File: rtl/jstk_tank_ctrl_if.sv
`timescale 1ns/1ps
// Joystick-in / tank-position-out bundle for jstk_tank_ctrl.
// The slave side is the controller; the master side is its environment.
interface jstk_tank_ctrl_if;
  logic [9:0]  jstk_x;
  logic [9:0]  jstk_y;
  logic        enable;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic [2:0]  dir;
  logic        moving;
  logic        pos_valid;

  modport master (
    output jstk_x, jstk_y, enable,
    input  pos_x, pos_y, dir, moving, pos_valid
  );

  modport slave (
    input  jstk_x, jstk_y, enable,
    output pos_x, pos_y, dir, moving, pos_valid
  );
endinterface

// File: rtl/jstk_tank_ctrl.sv
`timescale 1ns/1ps
// Converts joystick X/Y readings into a clamped tank position and 8-way heading once per tick.
// Optional build macro JSTK_FILTER_EN: 4-sample moving average of each axis before the deadzone.
module jstk_tank_ctrl #(
  parameter int TICK_DIV    = 1083333,
  parameter int CENTER      = 512,
  parameter int DEADZONE    = 64,
  parameter int SPEED_SHIFT = 7,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 991,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 735,
  parameter int X_INIT      = 496,
  parameter int Y_INIT      = 368
) (
  input  logic             clk,
  input  logic             rst,
  jstk_tank_ctrl_if.slave  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       state;

  logic [9:0]  eff_x, eff_y;
  logic signed [10:0] dx, dy;
  logic [10:0] mag_x, mag_y, step_x, step_y;
  logic        right, left, up, down;
  logic signed [11:0] ddx, ddy, new_x, new_y;
  logic [10:0] next_x, next_y;
  logic [2:0]  next_dir;

  logic [10:0] pos_x_q, pos_y_q;
  logic [2:0]  dir_q;
  logic        moving_q, pos_valid_q;

  function automatic logic [10:0] axis_step(input logic [10:0] mag);
    if (mag <= 11'(DEADZONE)) return 11'd0;
    return ((mag - 11'(DEADZONE)) >> SPEED_SHIFT) + 11'd1;
  endfunction

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Ticks seen outside IDLE, or with enable low, are simply not acted on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (tick && bus.enable) state <= S_SAMPLE;
        S_SAMPLE: state <= S_STEP;
        S_STEP:   state <= S_UPDATE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef JSTK_FILTER_EN
  logic [9:0]  hist_x [4];
  logic [9:0]  hist_y [4];
  logic [11:0] sum_x, sum_y;

  // NOTE: the history is a handful of flops, so it is reset to CENTER and the first averages start from rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_x[i] <= 10'(CENTER);
        hist_y[i] <= 10'(CENTER);
      end
    end else if (state == S_SAMPLE) begin
      hist_x[0] <= bus.jstk_x;
      hist_y[0] <= bus.jstk_y;
      for (int i = 1; i < 4; i++) begin
        hist_x[i] <= hist_x[i-1];
        hist_y[i] <= hist_y[i-1];
      end
    end
  end

  assign sum_x = 12'(hist_x[0]) + 12'(hist_x[1]) + 12'(hist_x[2]) + 12'(hist_x[3]);
  assign sum_y = 12'(hist_y[0]) + 12'(hist_y[1]) + 12'(hist_y[2]) + 12'(hist_y[3]);
  assign eff_x = 10'(sum_x >> 2);
  assign eff_y = 10'(sum_y >> 2);
`else
  logic [9:0] samp_x, samp_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_x <= 10'(CENTER);
      samp_y <= 10'(CENTER);
    end else if (state == S_SAMPLE) begin
      samp_x <= bus.jstk_x;
      samp_y <= bus.jstk_y;
    end
  end

  assign eff_x = samp_x;
  assign eff_y = samp_y;
`endif

  assign dx = $signed({1'b0, eff_x}) - $signed(11'(CENTER));
  assign dy = $signed({1'b0, eff_y}) - $signed(11'(CENTER));

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_dir = dir_q;
    mag_x    = dx[10] ? 11'(-dx) : 11'(dx);
    mag_y    = dy[10] ? 11'(-dy) : 11'(dy);
    step_x   = axis_step(mag_x);
    step_y   = axis_step(mag_y);
    right    = (step_x != 11'd0) && !dx[10];
    left     = (step_x != 11'd0) &&  dx[10];
    up       = (step_y != 11'd0) && !dy[10];
    down     = (step_y != 11'd0) &&  dy[10];

    // Joystick up moves toward screen row 0, so the Y delta is inverted.
    ddx = right ? $signed({1'b0, step_x}) : (left ? -$signed({1'b0, step_x}) : 12'sd0);
    ddy = up    ? -$signed({1'b0, step_y}) : (down ? $signed({1'b0, step_y}) : 12'sd0);

    new_x = $signed({1'b0, pos_x_q}) + ddx;
    new_y = $signed({1'b0, pos_y_q}) + ddy;

    if (new_x < $signed(12'(X_MIN)))      next_x = 11'(X_MIN);
    else if (new_x > $signed(12'(X_MAX))) next_x = 11'(X_MAX);
    else                                  next_x = new_x[10:0];

    if (new_y < $signed(12'(Y_MIN)))      next_y = 11'(Y_MIN);
    else if (new_y > $signed(12'(Y_MAX))) next_y = 11'(Y_MAX);
    else                                  next_y = new_y[10:0];

    case ({up, down, right, left})
      4'b1000: next_dir = 3'd0;
      4'b1010: next_dir = 3'd1;
      4'b0010: next_dir = 3'd2;
      4'b0110: next_dir = 3'd3;
      4'b0100: next_dir = 3'd4;
      4'b0101: next_dir = 3'd5;
      4'b0001: next_dir = 3'd6;
      4'b1001: next_dir = 3'd7;
      default: next_dir = dir_q;
    endcase
  end

  // Results are captured at the end of STEP so they, and pos_valid, are visible throughout UPDATE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x_q     <= 11'(X_INIT);
      pos_y_q     <= 11'(Y_INIT);
      dir_q       <= 3'd0;
      moving_q    <= 1'b0;
      pos_valid_q <= 1'b0;
    end else begin
      pos_valid_q <= 1'b0;
      if (state == S_STEP) begin
        pos_x_q     <= next_x;
        pos_y_q     <= next_y;
        dir_q       <= next_dir;
        moving_q    <= (ddx != 12'sd0) || (ddy != 12'sd0);
        pos_valid_q <= 1'b1;
      end
    end
  end

  assign bus.pos_x     = pos_x_q;
  assign bus.pos_y     = pos_y_q;
  assign bus.dir       = dir_q;
  assign bus.moving    = moving_q;
  assign bus.pos_valid = pos_valid_q;

endmodule
